// File: rtl/psram_qspi_responder.sv
`default_nettype none
// ============================================================================
//  Module   : psram_qspi_responder
//  Purpose  : QSPI PSRAM target. Oversamples sck/ce_n/sio with clk_i and
//             services quad read (0xEB) and quad write (0x38) bursts against
//             an internal 2^AW-byte array. MSB-nibble-first on all phases.
//  Ports    : clk_i     system clock (>= 8x sck frequency)
//             rst_n_i   asynchronous active-low reset
//             sck_i     serial clock from controller
//             ce_n_i    chip enable, active low
//             sio_i     controller-driven nibble (bit 3 = MSB)
//             sio_o     responder-driven nibble
//             sio_oe_o  output enables (all four bits identical)
//             busy_o    high while a frame is in progress
//             err_o     one-cycle pulse on an unsupported command
//  Params   : AW     byte-address width (AW <= 24)
//             DUMMY  wait cycles between address and first read nibble
//  Options  : PSRAM_RESP_PAGE_WRAP_EN - bursts wrap inside a 1024-byte page
//             (addr[9:0] increments, upper bits hold). Needs AW >= 10.
//  Revision : 1.0 - initial release
// ============================================================================
module psram_qspi_responder #(
    parameter int AW    = 12,
    parameter int DUMMY = 6
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic       sck_i,
    input  logic       ce_n_i,
    input  logic [3:0] sio_i,
    output logic [3:0] sio_o,
    output logic [3:0] sio_oe_o,
    output logic       busy_o,
    output logic       err_o
);

    localparam int          c_DEPTH      = 1 << AW;
    localparam logic [7:0]  c_DUMMY_LAST = 8'((DUMMY > 0) ? (DUMMY - 1) : 0);
    localparam logic [7:0]  c_CMD_READ   = 8'hEB;
    localparam logic [7:0]  c_CMD_WRITE  = 8'h38;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_CMD    = 3'd1,
        S_ADDR   = 3'd2,
        S_DUMMY  = 3'd3,
        S_RDATA  = 3'd4,
        S_WDATA  = 3'd5,
        S_IGNORE = 3'd6
    } state_t;

    // ------------------------------------------------------------------
    // Pin synchronizers and edge detection
    // ------------------------------------------------------------------
    logic [1:0] sck_sync_q;
    logic       sck_prev_q;
    logic [1:0] ce_sync_q;
    logic       ce_prev_q;
    logic [3:0] sio_s1_q;
    logic [3:0] sio_s2_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            sck_sync_q <= 2'b00;
            sck_prev_q <= 1'b0;
            ce_sync_q  <= 2'b11;
            ce_prev_q  <= 1'b1;
            sio_s1_q   <= 4'h0;
            sio_s2_q   <= 4'h0;
        end else begin
            sck_sync_q <= {sck_sync_q[0], sck_i};
            sck_prev_q <= sck_sync_q[1];
            ce_sync_q  <= {ce_sync_q[0], ce_n_i};
            ce_prev_q  <= ce_sync_q[1];
            sio_s1_q   <= sio_i;
            sio_s2_q   <= sio_s1_q;
        end
    end

    logic       w_rise;
    logic       w_fall;
    logic       w_ce_n;
    logic       w_ce_fall;
    logic [3:0] w_sio;

    // sio has the same synchronizer depth as sck, so at a rise pulse the
    // synchronized nibble is the one the controller set up before the pin edge.
    assign w_rise    =  sck_sync_q[1] & ~sck_prev_q;
    assign w_fall    = ~sck_sync_q[1] &  sck_prev_q;
    assign w_ce_n    =  ce_sync_q[1];
    assign w_ce_fall = ~ce_sync_q[1] &  ce_prev_q;
    assign w_sio     =  sio_s2_q;

    // ------------------------------------------------------------------
    // Datapath state
    // ------------------------------------------------------------------
    state_t          state_q;
    logic [7:0]      cnt_q;
    logic [19:0]     sh_q;
    logic            wr_q;
    logic [AW-1:0]   addr_q;
    logic [3:0]      hi_q;
    logic            half_q;
    logic [3:0]      sio_q;
    logic [3:0]      oe_q;
    logic            busy_q;
    logic            err_q;
    logic [7:0]      rd_q;

    logic [23:0]     w_sh_d;
    logic [AW-1:0]   w_addr_inc_d;
    logic            w_we;
    logic            w_unused_addr_hi;

    assign w_sh_d = {sh_q, w_sio};
    // Upper address bits above AW are accepted on the wire and discarded.
    assign w_unused_addr_hi = &{1'b0, w_sh_d};

    always_comb begin
        w_addr_inc_d = addr_q + {{(AW-1){1'b0}}, 1'b1};
`ifdef PSRAM_RESP_PAGE_WRAP_EN
        w_addr_inc_d       = addr_q;
        w_addr_inc_d[9:0]  = addr_q[9:0] + 10'd1;
`endif
    end

    // Second nibble of a write byte commits {hi, lo} to the array.
    assign w_we = (state_q == S_WDATA) && w_rise && half_q && !w_ce_n;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q <= S_IDLE;
            cnt_q   <= 8'd0;
            sh_q    <= 20'd0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            hi_q    <= 4'h0;
            half_q  <= 1'b0;
            sio_q   <= 4'h0;
            oe_q    <= 4'h0;
            busy_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (w_ce_n) begin
                // Deselect wins over everything: a partial byte is dropped.
                state_q <= S_IDLE;
                sio_q   <= 4'h0;
                oe_q    <= 4'h0;
                busy_q  <= 1'b0;
                half_q  <= 1'b0;
            end else begin
                case (state_q)
                    S_IDLE: begin
                        if (w_ce_fall) begin
                            state_q <= S_CMD;
                            busy_q  <= 1'b1;
                            cnt_q   <= 8'd0;
                            half_q  <= 1'b0;
                        end
                    end
                    S_CMD: begin
                        if (w_rise) begin
                            sh_q  <= w_sh_d[19:0];
                            cnt_q <= cnt_q + 8'd1;
                            if (cnt_q == 8'd1) begin
                                cnt_q <= 8'd0;
                                if (w_sh_d[7:0] == c_CMD_READ) begin
                                    wr_q    <= 1'b0;
                                    state_q <= S_ADDR;
                                end else if (w_sh_d[7:0] == c_CMD_WRITE) begin
                                    wr_q    <= 1'b1;
                                    state_q <= S_ADDR;
                                end else begin
                                    err_q   <= 1'b1;
                                    state_q <= S_IGNORE;
                                end
                            end
                        end
                    end
                    S_ADDR: begin
                        if (w_rise) begin
                            sh_q  <= w_sh_d[19:0];
                            cnt_q <= cnt_q + 8'd1;
                            if (cnt_q == 8'd5) begin
                                cnt_q  <= 8'd0;
                                half_q <= 1'b0;
                                addr_q <= w_sh_d[AW-1:0];
                                if (wr_q)
                                    state_q <= S_WDATA;
                                else if (DUMMY == 0)
                                    state_q <= S_RDATA;
                                else
                                    state_q <= S_DUMMY;
                            end
                        end
                    end
                    S_DUMMY: begin
                        if (w_rise) begin
                            cnt_q <= cnt_q + 8'd1;
                            if (cnt_q == c_DUMMY_LAST)
                                state_q <= S_RDATA;
                        end
                    end
                    S_RDATA: begin
                        // rd_q tracks mem[addr_q]; the address only moves after
                        // the low nibble, giving the read several cycles to settle.
                        if (w_fall) begin
                            oe_q   <= 4'hF;
                            half_q <= ~half_q;
                            if (half_q) begin
                                sio_q  <= rd_q[3:0];
                                addr_q <= w_addr_inc_d;
                            end else begin
                                sio_q  <= rd_q[7:4];
                            end
                        end
                    end
                    S_WDATA: begin
                        if (w_rise) begin
                            half_q <= ~half_q;
                            if (half_q)
                                addr_q <= w_addr_inc_d;
                            else
                                hi_q   <= w_sio;
                        end
                    end
                    S_IGNORE: begin
                        oe_q <= 4'h0;
                    end
                    default: begin
                        state_q <= S_IDLE;
                    end
                endcase
            end
        end
    end

    // ------------------------------------------------------------------
    // Single-port byte array: one write or one read per cycle, not reset.
    // ------------------------------------------------------------------
    logic [7:0] mem [c_DEPTH];

    always_ff @(posedge clk_i) begin
        if (w_we)
            mem[addr_q] <= {hi_q, w_sio};
        else
            rd_q <= mem[addr_q];
    end

    assign sio_o    = sio_q;
    assign sio_oe_o = oe_q;
    assign busy_o   = busy_q;
    assign err_o    = err_q;

endmodule
`default_nettype wire

// File: tb/tb_psram_qspi_responder.sv
`default_nettype none
// ============================================================================
//  Module   : tb_psram_qspi_responder
//  Purpose  : Self-checking bench for psram_qspi_responder. A table of read
//             bursts with expected bytes plus hand sequences for bad command,
//             mid-byte abort and reset during a read.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_psram_qspi_responder;

    localparam int AW      = 12;
    localparam int DUMMY_C = 6;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       sck;
    logic       ce_n;
    logic [3:0] sio;
    logic [3:0] sio_o;
    logic [3:0] sio_oe_o;
    logic       busy_o;
    logic       err_o;

    psram_qspi_responder #(.AW(AW), .DUMMY(DUMMY_C)) dut (
        .clk_i    (clk),
        .rst_n_i  (rst_n),
        .sck_i    (sck),
        .ce_n_i   (ce_n),
        .sio_i    (sio),
        .sio_o    (sio_o),
        .sio_oe_o (sio_oe_o),
        .busy_o   (busy_o),
        .err_o    (err_o)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;
    int err_pulses = 0;
    int oe_hits    = 0;

    always @(negedge clk) begin
        if (err_o === 1'b1) err_pulses++;
        if (sio_oe_o !== 4'h0) oe_hits++;
    end

    typedef struct {
        logic [23:0] addr;
        int          nbytes;
        logic [31:0] exp;     // expected bytes, first byte in [31:24]
    } rd_vec_t;

    rd_vec_t vt [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic wclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic clk_nib(input logic [3:0] n);
        sio = n;
        wclk(5);
        sck = 1'b1;
        wclk(5);
        sck = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b);
        clk_nib(b[7:4]);
        clk_nib(b[3:0]);
    endtask

    task automatic start_frame(input logic [7:0] cmd, input logic [23:0] addr);
        ce_n = 1'b0;
        wclk(5);
        send_byte(cmd);
        send_byte(addr[23:16]);
        send_byte(addr[15:8]);
        send_byte(addr[7:0]);
    endtask

    task automatic end_frame();
        wclk(5);
        ce_n = 1'b1;
        wclk(10);
    endtask

    task automatic write_bytes(input logic [23:0] addr, input int n, input logic [31:0] data);
        start_frame(8'h38, addr);
        for (int i = 0; i < n; i++) send_byte(data[31-8*i -: 8]);
        end_frame();
    endtask

    task automatic read_nib(output logic [3:0] n, inout int oe_bad);
        wclk(5);
        n = sio_o;
        if (sio_oe_o !== 4'hF) oe_bad++;
        sck = 1'b1;
        wclk(5);
        sck = 1'b0;
    endtask

    task automatic dummies(output logic [3:0] oe_pre);
        oe_pre = 4'h0;
        for (int d = 0; d < DUMMY_C; d++) begin
            sio = 4'h0;
            wclk(5);
            oe_pre = oe_pre | sio_oe_o;
            sck = 1'b1;
            wclk(5);
            sck = 1'b0;
        end
    endtask

    task automatic read_bytes(input logic [23:0] addr, input int n,
                              output logic [31:0] got, output int oe_bad,
                              output logic [3:0] oe_pre);
        logic [3:0] h, l;
        got    = 32'h0;
        oe_bad = 0;
        start_frame(8'hEB, addr);
        dummies(oe_pre);
        for (int i = 0; i < n; i++) begin
            read_nib(h, oe_bad);
            read_nib(l, oe_bad);
            got[31-8*i -: 8] = {h, l};
        end
        end_frame();
    endtask

    task automatic run_vec(input rd_vec_t v, input string tag);
        logic [31:0] got;
        int          oe_bad;
        logic [3:0]  oe_pre;
        logic [31:0] mask;
        mask = 32'hFFFF_FFFF << (32 - 8*v.nbytes);
        read_bytes(v.addr, v.nbytes, got, oe_bad, oe_pre);
        check({tag, " data"},      got & mask, v.exp & mask);
        check({tag, " oe_pre"},    {28'h0, oe_pre}, 32'h0);
        check({tag, " oe_data"},   oe_bad, 0);
        check({tag, " oe_after"},  {28'h0, sio_oe_o}, 32'h0);
    endtask

    initial begin
        logic [3:0] nib;
        int         ob;
        logic [3:0] op;

        vt[0] = '{addr: 24'h000010, nbytes: 4, exp: 32'hA53C_7E01};
        vt[1] = '{addr: 24'h000012, nbytes: 2, exp: 32'h7E01_0000};
        vt[2] = '{addr: 24'hAB0010, nbytes: 1, exp: 32'hA500_0000};
`ifdef PSRAM_RESP_PAGE_WRAP_EN
        vt[3] = '{addr: 24'h0003FF, nbytes: 2, exp: 32'hAABB_0000};
        vt[4] = '{addr: 24'h000000, nbytes: 1, exp: 32'hBB00_0000};
        vt[5] = '{addr: 24'h000400, nbytes: 1, exp: 32'hCC00_0000};
`else
        vt[3] = '{addr: 24'h000FFF, nbytes: 2, exp: 32'h1122_0000};
        vt[4] = '{addr: 24'h000000, nbytes: 1, exp: 32'h2200_0000};
        vt[5] = '{addr: 24'h000FFF, nbytes: 1, exp: 32'h1100_0000};
`endif

        rst_n = 1'b0;
        sck   = 1'b0;
        ce_n  = 1'b1;
        sio   = 4'h0;
        wclk(4);
        check("reset sio_o",    {28'h0, sio_o},    32'h0);
        check("reset sio_oe_o", {28'h0, sio_oe_o}, 32'h0);
        check("reset busy_o",   {31'h0, busy_o},   32'h0);
        check("reset err_o",    {31'h0, err_o},    32'h0);
        rst_n = 1'b1;
        wclk(5);

        // Preload memory
        write_bytes(24'h000010, 4, 32'hA53C_7E01);
`ifdef PSRAM_RESP_PAGE_WRAP_EN
        write_bytes(24'h000400, 1, 32'hCC00_0000);
        write_bytes(24'h0003FF, 2, 32'hAABB_0000);
`else
        write_bytes(24'h000FFF, 1, 32'h1100_0000);
        write_bytes(24'h000000, 1, 32'h2200_0000);
`endif

        for (int i = 0; i < 6; i++) run_vec(vt[i], $sformatf("vec%0d", i));

        // Unsupported command: single err pulse, never drives, next frame fine
        err_pulses = 0;
        oe_hits    = 0;
        ce_n = 1'b0;
        wclk(5);
        send_byte(8'h9F);
        for (int i = 0; i < 16; i++) clk_nib(4'hF);
        check("badcmd busy", {31'h0, busy_o}, 32'h1);
        end_frame();
        check("badcmd err pulses", err_pulses, 1);
        check("badcmd oe",         oe_hits,    0);
        run_vec(vt[2], "after_badcmd");

        // Abort after three write nibbles
        write_bytes(24'h000020, 2, 32'h5566_0000);
        start_frame(8'h38, 24'h000020);
        clk_nib(4'h9);
        clk_nib(4'h1);
        clk_nib(4'h7);
        wclk(5);
        check("abort busy before", {31'h0, busy_o}, 32'h1);
        ce_n = 1'b1;
        wclk(3);
        check("abort busy 3clk", {31'h0, busy_o}, 32'h0);
        wclk(10);
        run_vec('{addr: 24'h000020, nbytes: 2, exp: 32'h9166_0000}, "abort");

        // Reset asserted in the middle of a read burst
        start_frame(8'hEB, 24'h000010);
        dummies(op);
        ob = 0;
        read_nib(nib, ob);
        check("rst mid nib", {28'h0, nib}, 32'hA);
        wclk(4);
        check("rst mid oe", {28'h0, sio_oe_o}, 32'hF);
        rst_n = 1'b0;
        #1;
        check("rst async oe",   {28'h0, sio_oe_o}, 32'h0);
        check("rst async busy", {31'h0, busy_o},   32'h0);
        check("rst async sio",  {28'h0, sio_o},    32'h0);
        ce_n = 1'b1;
        wclk(5);
        rst_n = 1'b1;
        wclk(5);
        run_vec(vt[0], "after_rst");

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
